// File: rtl/iob_ptfloat2double_arb_pkg.sv
// Shared types and width helpers for the pt-float to double
// arbiter slice.
package iob_ptfloat2double_arb_pkg;

   localparam int FP_DP_DATA_W = 64;

   typedef enum logic [1:0] {
      PTF2D_IDLE  = 2'd0,
      PTF2D_ISSUE = 2'd1,
      PTF2D_WAIT  = 2'd2,
      PTF2D_RESP  = 2'd3
   } ptf2d_state_t;

   // Widest exponent/mantissa a pt-float word can carry
   function automatic int exp_max_w(input int ew_w);
      return (1 << ew_w) - 1;
   endfunction

   function automatic int man_max_w(input int data_w,
                                    input int ew_w);
      return data_w - ew_w - 1;
   endfunction

endpackage

// File: rtl/iob_rr_arbiter.sv
// Round-robin arbiter: first request at or above ptr, with
// wrap, wins. Purely combinational.
module iob_rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [ID_W-1:0]  gnt_idx,
   output logic             gnt_vld
);

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_vld = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         int j;
         j = int'(ptr) + i;
         if (j >= N_REQ) j = j - N_REQ;
         if (!gnt_vld && req[j]) begin
            gnt[j]  = 1'b1;
            gnt_idx = ID_W'(j);
            gnt_vld = 1'b1;
         end
      end
   end

endmodule

// File: rtl/iob_ptfloat2double_arb.sv
// Shares one pt-float to double converter between N_REQ
// requesters; one conversion in flight at a time.
module iob_ptfloat2double_arb
   import iob_ptfloat2double_arb_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int EW_W   = 4,
   parameter int N_REQ  = 4,
   localparam int ID_W  = $clog2(N_REQ),
   localparam int EXP_W = exp_max_w(EW_W),
   localparam int MAN_W = man_max_w(DATA_W, EW_W),
   localparam int FP_W  = FP_DP_DATA_W
) (
   input  logic               clk_i,
   input  logic               arst_n_i,
   input  logic               cke_i,
   input  logic [N_REQ-1:0]   req_valid_i,
   output logic [N_REQ-1:0]   req_ready_o,
   input  logic [N_REQ*EXP_W-1:0] req_exp_i,
   input  logic [N_REQ*MAN_W-1:0] req_man_i,
   output logic               cvt_start_o,
   input  logic               cvt_done_i,
   output logic [EXP_W-1:0]   cvt_exp_o,
   output logic [MAN_W-1:0]   cvt_man_o,
   input  logic [FP_W-1:0]    cvt_fp_i,
   output logic               rsp_valid_o,
   input  logic               rsp_ready_i,
   output logic [ID_W-1:0]    rsp_id_o,
   output logic [FP_W-1:0]    rsp_fp_o,
   output logic               busy_o
);

   ptf2d_state_t state, state_d;

   logic [ID_W-1:0]  ptr_q;
   logic [ID_W-1:0]  id_q;
   logic [EXP_W-1:0] exp_q;
   logic [MAN_W-1:0] man_q;
   logic [FP_W-1:0]  fp_q;
   logic             vld_q;

   logic [N_REQ-1:0] gnt;
   logic [ID_W-1:0]  gnt_idx;
   logic             gnt_vld;
   logic [ID_W-1:0]  ptr_nxt;
   logic             acc;
   logic             cap;
   logic             hs;

   iob_rr_arbiter #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_arb (
      .req     (req_valid_i),
      .ptr     (ptr_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld)
   );

   // Explicit wrap so non-power-of-two N_REQ stays in range
   assign ptr_nxt = (gnt_idx == ID_W'(N_REQ - 1)) ?
                    '0 : gnt_idx + ID_W'(1);

   always_comb begin
      state_d = state;
      acc     = 1'b0;
      cap     = 1'b0;
      hs      = 1'b0;
      unique case (state)
         PTF2D_IDLE: begin
            if (gnt_vld) begin
               acc     = 1'b1;
               state_d = PTF2D_ISSUE;
            end
         end
         PTF2D_ISSUE: begin
            if (cvt_done_i) begin
               cap     = 1'b1;
               state_d = PTF2D_RESP;
            end else begin
               state_d = PTF2D_WAIT;
            end
         end
         PTF2D_WAIT: begin
            if (cvt_done_i) begin
               cap     = 1'b1;
               state_d = PTF2D_RESP;
            end
         end
         PTF2D_RESP: begin
            if (rsp_ready_i) begin
               hs      = 1'b1;
               state_d = PTF2D_IDLE;
            end
         end
         default: state_d = PTF2D_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         state <= PTF2D_IDLE;
         ptr_q <= '0;
         id_q  <= '0;
         exp_q <= '0;
         man_q <= '0;
         fp_q  <= '0;
         vld_q <= 1'b0;
      end else if (cke_i) begin
         state <= state_d;
         if (acc) begin
            exp_q <= req_exp_i[gnt_idx*EXP_W +: EXP_W];
            man_q <= req_man_i[gnt_idx*MAN_W +: MAN_W];
            id_q  <= gnt_idx;
            ptr_q <= ptr_nxt;
         end
         if (cap) begin
            fp_q  <= cvt_fp_i;
            vld_q <= 1'b1;
         end
         if (hs) vld_q <= 1'b0;
      end
   end

   // Ready is combinational, so it is also masked while in reset
   assign req_ready_o = (state == PTF2D_IDLE && cke_i && arst_n_i) ?
                        gnt : '0;
   assign cvt_start_o = (state == PTF2D_ISSUE) && cke_i;
   assign cvt_exp_o   = exp_q;
   assign cvt_man_o   = man_q;
   assign rsp_valid_o = vld_q;
   assign rsp_id_o    = id_q;
   assign rsp_fp_o    = fp_q;
   assign busy_o      = (state != PTF2D_IDLE);

endmodule

// File: tb/tb_iob_ptfloat2double_arb.sv
// Directed self-checking bench for iob_ptfloat2double_arb.
// Converter is modelled by driving cvt_done_i/cvt_fp_i by hand.
module tb_iob_ptfloat2double_arb;
   import iob_ptfloat2double_arb_pkg::*;

   localparam int N  = 4;
   localparam int IW = 2;
   localparam int EW = exp_max_w(4);
   localparam int MW = man_max_w(32, 4);
   localparam int FW = FP_DP_DATA_W;

   logic          clk = 1'b0;
   logic          arst_n;
   logic          cke;
   logic [N-1:0]  req_valid;
   logic [N-1:0]  req_ready;
   logic [N*EW-1:0] req_exp;
   logic [N*MW-1:0] req_man;
   logic          cvt_start;
   logic          cvt_done;
   logic [EW-1:0] cvt_exp;
   logic [MW-1:0] cvt_man;
   logic [FW-1:0] cvt_fp;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [IW-1:0] rsp_id;
   logic [FW-1:0] rsp_fp;
   logic          busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   iob_ptfloat2double_arb #(
      .DATA_W (32),
      .EW_W   (4),
      .N_REQ  (N)
   ) dut (
      .clk_i       (clk),
      .arst_n_i    (arst_n),
      .cke_i       (cke),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_exp_i   (req_exp),
      .req_man_i   (req_man),
      .cvt_start_o (cvt_start),
      .cvt_done_i  (cvt_done),
      .cvt_exp_o   (cvt_exp),
      .cvt_man_o   (cvt_man),
      .cvt_fp_i    (cvt_fp),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rsp_id_o    (rsp_id),
      .rsp_fp_o    (rsp_fp),
      .busy_o      (busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      cke       = 1'b1;
      req_valid = '0;
      req_exp   = '0;
      req_man   = '0;
      cvt_done  = 1'b0;
      cvt_fp    = '0;
      rsp_ready = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      arst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      arst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      logic [N+1+EW+MW+1+IW+FW:0] outs;
      arst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cke       = 1'($urandom);
         req_valid = N'($urandom);
         req_exp   = {$urandom, $urandom};
         req_man   = {$urandom, $urandom, $urandom, $urandom};
         cvt_done  = 1'($urandom);
         cvt_fp    = {$urandom, $urandom};
         rsp_ready = 1'($urandom);
         @(posedge clk);
         #2;
         outs = {req_ready, cvt_start, cvt_exp, cvt_man,
                 rsp_valid, rsp_id, rsp_fp, busy};
         checks++;
         if (outs !== '0) begin
            errors++;
            $display("FAIL reset_outs iter %0d got %h want 0",
                     i, outs);
         end
      end
      clear_inputs();
      arst_n = 1'b1;
      tick();
      checks++;
      if (busy !== 1'b0 || req_ready !== '0) begin
         errors++;
         $display("FAIL reset_release busy %b ready %b want 0 0",
                  busy, req_ready);
      end
   endtask

   task automatic test_single();
      do_reset();
      req_exp[2*EW +: EW] = 15'h0123;
      req_man[2*MW +: MW] = 27'h0ABCDEF;
      req_valid = 4'b0100;
      #1;
      checks++;
      if (req_ready !== 4'b0100 || cvt_start !== 1'b0) begin
         errors++;
         $display("FAIL single_c0 ready %b start %b want 0100 0",
                  req_ready, cvt_start);
      end
      tick();
      req_valid = '0;
      #1;
      checks++;
      if (cvt_start !== 1'b1 || cvt_exp !== 15'h0123 ||
          cvt_man !== 27'h0ABCDEF) begin
         errors++;
         $display("FAIL single_c1 start %b exp %h man %h want 1 0123 0abcdef",
                  cvt_start, cvt_exp, cvt_man);
      end
      tick();
      checks++;
      if (cvt_start !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL single_c2 start %b busy %b want 0 1",
                  cvt_start, busy);
      end
      tick();
      tick();
      cvt_done = 1'b1;
      cvt_fp   = 64'h3FF0000000000000;
      #1;
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_c4 rsp_valid %b want 0", rsp_valid);
      end
      tick();
      cvt_done = 1'b0;
      cvt_fp   = '0;
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 ||
          rsp_fp !== 64'h3FF0000000000000) begin
         errors++;
         $display("FAIL single_c5 valid %b id %0d fp %h want 1 2 3ff0000000000000",
                  rsp_valid, rsp_id, rsp_fp);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL single_hs valid %b busy %b want 0 0",
                  rsp_valid, busy);
      end
   endtask

   task automatic test_fairness();
      int got [5];
      int n = 0;
      do_reset();
      req_valid = 4'b1111;
      rsp_ready = 1'b1;
      cvt_done  = 1'b1;
      #1;
      for (int c = 0; c < 40 && n < 5; c++) begin
         if (req_ready !== '0) begin
            checks++;
            if ($countones(req_ready) != 1) begin
               errors++;
               $display("FAIL fair_onehot got %b want one-hot",
                        req_ready);
            end
            for (int r = 0; r < N; r++)
               if (req_ready[r]) got[n] = r;
            n++;
         end
         tick();
      end
      checks++;
      if (n != 5) begin
         errors++;
         $display("FAIL fair_count got %0d grants want 5", n);
      end
      for (int i = 0; i < n; i++) begin
         checks++;
         if (got[i] != i % N) begin
            errors++;
            $display("FAIL fair_order grant %0d got %0d want %0d",
                     i, got[i], i % N);
         end
      end
      clear_inputs();
   endtask

   task automatic test_back_to_back();
      do_reset();
      req_valid = 4'b0001;
      #1;
      tick();
      req_valid = 4'b1111;
      cvt_done  = 1'b1;
      cvt_fp    = 64'hC000000000000000;
      #1;
      checks++;
      if (cvt_start !== 1'b1) begin
         errors++;
         $display("FAIL bp_start got %b want 1", cvt_start);
      end
      tick();
      cvt_done = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cvt_fp = {32'h1234_5678, 32'(i)};
         #1;
         checks++;
         if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 ||
             rsp_fp !== 64'hC000000000000000 ||
             req_ready !== '0 || cvt_start !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold cyc %0d v %b id %0d fp %h rdy %b st %b want 1 0 c000000000000000 0 0",
                     i, rsp_valid, rsp_id, rsp_fp, req_ready,
                     cvt_start);
         end
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 4'b0010) begin
         errors++;
         $display("FAIL bp_release valid %b ready %b want 0 0010",
                  rsp_valid, req_ready);
      end
      clear_inputs();
   endtask

   task automatic test_zero_latency();
      do_reset();
      req_valid = 4'b1000;
      #1;
      tick();
      req_valid = '0;
      cvt_done  = 1'b1;
      cvt_fp    = 64'h4008000000000000;
      #1;
      checks++;
      if (cvt_start !== 1'b1) begin
         errors++;
         $display("FAIL zl_start got %b want 1", cvt_start);
      end
      tick();
      cvt_done = 1'b0;
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 ||
          rsp_fp !== 64'h4008000000000000) begin
         errors++;
         $display("FAIL zl_rsp v %b id %0d fp %h want 1 3 4008000000000000",
                  rsp_valid, rsp_id, rsp_fp);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      cvt_done  = 1'b1;
      cvt_fp    = 64'hDEADBEEF00000000;
      tick();
      cvt_done = 1'b0;
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0 ||
          rsp_fp !== 64'h4008000000000000) begin
         errors++;
         $display("FAIL stray_done v %b busy %b fp %h want 0 0 4008000000000000",
                  rsp_valid, busy, rsp_fp);
      end
      req_valid = 4'b1111;
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++;
         $display("FAIL wrap_ptr ready %b want 0001", req_ready);
      end
      clear_inputs();
   endtask

   task automatic test_cke_and_reset();
      do_reset();
      cke       = 1'b0;
      req_valid = 4'b0010;
      #1;
      checks++;
      if (req_ready !== '0) begin
         errors++;
         $display("FAIL cke_ready got %b want 0", req_ready);
      end
      tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL cke_idle busy %b want 0", busy);
      end
      cke = 1'b1;
      #1;
      tick();
      req_valid = '0;
      tick();
      cke      = 1'b0;
      cvt_done = 1'b1;
      cvt_fp   = 64'h7FF0000000000000;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if (rsp_valid !== 1'b0 || busy !== 1'b1 ||
             cvt_start !== 1'b0) begin
            errors++;
            $display("FAIL cke_freeze cyc %0d v %b busy %b st %b want 0 1 0",
                     i, rsp_valid, busy, cvt_start);
         end
         tick();
      end
      cke      = 1'b1;
      cvt_done = 1'b0;
      tick();
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL cke_wait v %b busy %b want 0 1",
                  rsp_valid, busy);
      end
      arst_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_wait busy %b v %b want 0 0",
                  busy, rsp_valid);
      end
      tick();
      arst_n   = 1'b1;
      cvt_done = 1'b1;
      tick();
      cvt_done = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_after busy %b v %b want 0 0",
                  busy, rsp_valid);
      end
      clear_inputs();
   endtask

   initial begin
      arst_n = 1'b0;
      clear_inputs();
      test_reset();
      test_single();
      test_fairness();
      test_back_to_back();
      test_zero_latency();
      test_cke_and_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
